// File: rtl/led_panel_shift_driver_pkg.sv
// Shared types and helpers for the LED panel shift-register driver.
package led_panel_shift_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH
  } state_e;

  // Width of a counter that must hold 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_panel_tick_counter.sv
// Modulo-N counter with enable and clear; wrap_o pulses on the last count.
module led_panel_tick_counter
  import led_panel_shift_driver_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic wrap_o
);

  localparam int          W    = cnt_w(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count;

  // Clear wins over a wrap so a restart never produces a stray pulse.
  assign wrap_o = en && !clr && (count == LAST);

  // Count up while enabled, folding back to zero after N-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    count <= '0;
    else if (clr)    count <= '0;
    else if (en)     count <= (count == LAST) ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/led_panel_shift_driver.sv
// Serialises the LED PIO vector into a 74HC595-style chain with latch and OE.
// Re-sends on any input change and on a periodic refresh after idle time.
module led_panel_shift_driver
  import led_panel_shift_driver_pkg::*;
#(
  parameter int DATA_WIDTH     = 21,
  parameter int CHAIN_WIDTH    = 24,
  parameter int CLK_DIV        = 4,
  parameter int REFRESH_CYCLES = 50000000,
  parameter int LED_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] led_i,
  output logic                  panel_sclk_o,
  output logic                  panel_sdata_o,
  output logic                  panel_latch_o,
  output logic                  panel_oe_n_o,
  output logic                  busy_o,
  output logic                  frame_done_o
);

  localparam int   BW     = cnt_w(CHAIN_WIDTH);
  localparam int   REF_N  = (REFRESH_CYCLES > 0) ? REFRESH_CYCLES : 1;
  localparam bit   REF_EN = (REFRESH_CYCLES > 0);
  localparam logic INV    = (LED_ACTIVE_LOW != 0);

  state_e                 state;
  logic [CHAIN_WIDTH-1:0] shreg;
  logic [CHAIN_WIDTH-1:0] shreg_nx;
  logic [CHAIN_WIDTH-1:0] snap;
  logic [DATA_WIDTH-1:0]  last_sent;
  logic [BW-1:0]          bit_cnt;
  logic                   pend_flag;
  logic                   changed;
  logic                   div_en;
  logic                   div_wrap;
  logic                   ref_clr;
  logic                   ref_wrap;

  // Pad bits are inverted too, so an active-low chain sees them as "off".
  assign snap     = CHAIN_WIDTH'(led_i) ^ {CHAIN_WIDTH{INV}};
  assign shreg_nx = shreg << 1;

  // Change detect is live rather than sticky: a glitch that reverts before
  // the frame ends leaves nothing to resend.
  assign changed = (led_i != last_sent);

  assign div_en  = (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI) ||
                   (state == ST_LATCH);

  // Refresh restarts both at LOAD and at frame end, so it measures idle time.
  assign ref_clr = (state == ST_LOAD) || ((state == ST_LATCH) && div_wrap);

  led_panel_tick_counter #(.N(CLK_DIV)) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (div_en),
    .clr     (state == ST_LOAD),
    .wrap_o  (div_wrap)
  );

  led_panel_tick_counter #(.N(REF_N)) u_refresh (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (REF_EN),
    .clr     (ref_clr),
    .wrap_o  (ref_wrap)
  );

  // Frame sequencer with registered panel outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      shreg         <= '0;
      last_sent     <= '0;
      bit_cnt       <= '0;
      pend_flag     <= 1'b1;
      panel_sclk_o  <= 1'b0;
      panel_sdata_o <= 1'b0;
      panel_latch_o <= 1'b0;
      panel_oe_n_o  <= 1'b1;
      busy_o        <= 1'b0;
      frame_done_o  <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (ref_wrap) pend_flag <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (pend_flag || changed || ref_wrap) state <= ST_LOAD;
        end
        ST_LOAD: begin
          shreg         <= snap;
          last_sent     <= led_i;
          pend_flag     <= 1'b0;
          bit_cnt       <= BW'(CHAIN_WIDTH - 1);
          panel_sdata_o <= snap[CHAIN_WIDTH-1];
          panel_sclk_o  <= 1'b0;
          busy_o        <= 1'b1;
          state         <= ST_SHIFT_LO;
        end
        ST_SHIFT_LO: begin
          if (div_wrap) begin
            panel_sclk_o <= 1'b1;
            state        <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (div_wrap) begin
            panel_sclk_o <= 1'b0;
            if (bit_cnt == '0) begin
              panel_latch_o <= 1'b1;
              state         <= ST_LATCH;
            end else begin
              shreg         <= shreg_nx;
              bit_cnt       <= bit_cnt - 1'b1;
              panel_sdata_o <= shreg_nx[CHAIN_WIDTH-1];
              state         <= ST_SHIFT_LO;
            end
          end
        end
        ST_LATCH: begin
          if (div_wrap) begin
            panel_latch_o <= 1'b0;
            busy_o        <= 1'b0;
            frame_done_o  <= 1'b1;
            panel_oe_n_o  <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_panel_shift_driver.sv
// Bench: three driver instances (default, active-low, fast refresh) share
// clock and reset; a serial monitor rebuilds each frame and pops the
// expected word from a per-instance queue.
module tb_led_panel_shift_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [20:0] led0, led1, led2;
  logic [2:0]  sclk, sdata, latch, oe_n, busy, fdone;

  int cyc = 0;
  int chk = 0;
  int err = 0;

  logic [23:0] q0[$], q1[$], q2[$];
  logic [23:0] last_exp[3];
  logic [23:0] word[3];
  int          nbits[3], latch_len[3], frames[3], busy_rise[3], period[3];
  logic        prev_sclk[3], prev_busy[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_panel_shift_driver u_dut0 (
    .clk(clk), .reset_n(reset_n), .led_i(led0),
    .panel_sclk_o(sclk[0]), .panel_sdata_o(sdata[0]), .panel_latch_o(latch[0]),
    .panel_oe_n_o(oe_n[0]), .busy_o(busy[0]), .frame_done_o(fdone[0]));

  led_panel_shift_driver #(.LED_ACTIVE_LOW(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .led_i(led1),
    .panel_sclk_o(sclk[1]), .panel_sdata_o(sdata[1]), .panel_latch_o(latch[1]),
    .panel_oe_n_o(oe_n[1]), .busy_o(busy[1]), .frame_done_o(fdone[1]));

  led_panel_shift_driver #(.REFRESH_CYCLES(1000)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .led_i(led2),
    .panel_sclk_o(sclk[2]), .panel_sdata_o(sdata[2]), .panel_latch_o(latch[2]),
    .panel_oe_n_o(oe_n[2]), .busy_o(busy[2]), .frame_done_o(fdone[2]));

  // Reference model of the shifted word.
  function automatic logic [23:0] exp_word(input logic [20:0] v, input bit inv);
    logic [23:0] w;
    w = {3'b000, v};
    return inv ? ~w : w;
  endfunction

  // Rebuilds frames from SCLK rising edges and scores them at frame_done.
  task automatic monitor();
    logic [23:0] e;
    bit          have;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!reset_n) begin
          nbits[i] = 0; word[i] = '0; latch_len[i] = 0;
          prev_sclk[i] = 1'b0; prev_busy[i] = 1'b0;
        end else begin
          if (sclk[i] && !prev_sclk[i]) begin
            word[i]  = {word[i][22:0], sdata[i]};
            nbits[i] = nbits[i] + 1;
          end
          if (latch[i]) latch_len[i] = latch_len[i] + 1;
          if (busy[i] && !prev_busy[i]) begin
            period[i]    = cyc - busy_rise[i];
            busy_rise[i] = cyc;
          end
          if (fdone[i]) begin
            have = 1'b0;
            e    = '0;
            case (i)
              0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
              1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
              default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            // The refresh instance may resend its last word unprompted.
            if (!have && i == 2) begin e = last_exp[2]; have = 1'b1; end
            if (have) last_exp[i] = e;
            chk++;
            if (!have) begin
              err++;
              $display("FAIL frame_unexpected dut%0d: got %h, none expected", i, word[i]);
            end else if (word[i] !== e) begin
              err++;
              $display("FAIL frame_data dut%0d: got %h, expected %h", i, word[i], e);
            end
            chk++;
            if (nbits[i] !== 24) begin
              err++;
              $display("FAIL sclk_edges dut%0d: got %0d, expected 24", i, nbits[i]);
            end
            chk++;
            if (latch_len[i] !== 4) begin
              err++;
              $display("FAIL latch_width dut%0d: got %0d, expected 4", i, latch_len[i]);
            end
            frames[i]    = frames[i] + 1;
            nbits[i]     = 0;
            latch_len[i] = 0;
            word[i]      = '0;
          end
          prev_sclk[i] = sclk[i];
          prev_busy[i] = busy[i];
        end
      end
    end
  endtask

  task automatic wait_fdone(input int i, input int budget, input string name,
                            output bit oe_low_before);
    bit hit;
    hit = 1'b0;
    oe_low_before = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (fdone[i]) begin hit = 1'b1; break; end
      if (!oe_n[i]) oe_low_before = 1'b1;
    end
    if (!hit) begin
      chk++; err++;
      $display("FAIL %s: no frame_done on dut%0d within %0d cycles", name, i, budget);
    end
  endtask

  task automatic wait_bits(input int i, input int n, input int budget, input string name);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (nbits[i] >= n) begin hit = 1'b1; break; end
    end
    if (!hit) begin
      chk++; err++;
      $display("FAIL %s: dut%0d reached %0d bits, expected %0d", name, i, nbits[i], n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    led0 = 21'h15555;
    led1 = 21'h000001;
    led2 = 21'h0ABCD;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk++;
      if ({sclk[i], sdata[i], latch[i], oe_n[i], busy[i], fdone[i]} !== 6'b000100) begin
        err++;
        $display("FAIL reset_outputs dut%0d: got %b, expected 000100", i,
                 {sclk[i], sdata[i], latch[i], oe_n[i], busy[i], fdone[i]});
      end
    end
    q0.push_back(exp_word(led0, 1'b0));
    q1.push_back(exp_word(led1, 1'b1));
    q2.push_back(exp_word(led2, 1'b0));
  endtask

  task automatic test_first_frame();
    int rel;
    bit oe_early;
    rel = cyc;
    reset_n = 1'b1;
    wait_fdone(0, 400, "first_frame", oe_early);
    chk++;
    if (cyc - rel !== 198) begin
      err++; $display("FAIL first_done_time: got %0d, expected 198", cyc - rel);
    end
    chk++;
    if (busy_rise[0] - rel !== 2) begin
      err++; $display("FAIL first_busy_time: got %0d, expected 2", busy_rise[0] - rel);
    end
    chk++;
    if (oe_early !== 1'b0) begin
      err++; $display("FAIL oe_before_latch: got low, expected high until frame_done");
    end
    chk++;
    if (oe_n[0] !== 1'b0) begin
      err++; $display("FAIL oe_at_done: got %b, expected 0", oe_n[0]);
    end
    repeat (10) @(negedge clk);
    chk++;
    if ({oe_n[0], oe_n[1], busy[0]} !== 3'b000) begin
      err++; $display("FAIL oe_sticky: got %b, expected 000", {oe_n[0], oe_n[1], busy[0]});
    end
  endtask

  task automatic test_change_mid_frame();
    int d;
    bit dummy;
    led0 = 21'h1;
    q0.push_back(exp_word(21'h1, 1'b0));
    wait_bits(0, 10, 400, "change_bit10");
    led0 = 21'h2;
    q0.push_back(exp_word(21'h2, 1'b0));
    wait_fdone(0, 400, "change_frame1", dummy);
    d = cyc;
    wait_fdone(0, 400, "change_frame2", dummy);
    chk++;
    if (busy_rise[0] - d < 1 || busy_rise[0] - d > 2) begin
      err++; $display("FAIL change_restart_gap: got %0d, expected 1..2", busy_rise[0] - d);
    end
  endtask

  task automatic test_glitch();
    int f;
    bit dummy;
    led0 = 21'h3;
    q0.push_back(exp_word(21'h3, 1'b0));
    wait_bits(0, 5, 400, "glitch_bit5");
    led0 = 21'h7;
    wait_bits(0, 15, 400, "glitch_bit15");
    led0 = 21'h3;
    wait_fdone(0, 400, "glitch_frame", dummy);
    @(negedge clk);
    f = frames[0];
    repeat (300) @(negedge clk);
    chk++;
    if (frames[0] !== f) begin
      err++; $display("FAIL glitch_extra_frame: got %0d frames, expected %0d", frames[0], f);
    end
    chk++;
    if (busy[0] !== 1'b0) begin
      err++; $display("FAIL glitch_busy: got %b, expected 0", busy[0]);
    end
  endtask

  task automatic test_active_low();
    bit dummy;
    led1 = 21'h0F0F0;
    q1.push_back(exp_word(21'h0F0F0, 1'b1));
    wait_fdone(1, 400, "active_low_frame", dummy);
  endtask

  task automatic test_refresh();
    int f;
    bit hit;
    f = frames[2];
    hit = 1'b0;
    for (int k = 0; k < 2700; k++) begin
      @(negedge clk);
      if (frames[2] >= f + 2) begin hit = 1'b1; break; end
    end
    chk++;
    if (!hit) begin
      err++; $display("FAIL refresh_frames: got %0d new frames, expected 2", frames[2] - f);
    end else if (period[2] < 1196 || period[2] > 1198) begin
      err++; $display("FAIL refresh_period: got %0d, expected 1196..1198", period[2]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int rel;
    bit oe_early;
    led0 = 21'h0AAAA;
    q0.push_back(exp_word(21'h0AAAA, 1'b0));
    wait_bits(0, 12, 400, "reset_bit12");
    #2 reset_n = 1'b0;
    #1;
    chk++;
    if ({sclk[0], sdata[0], latch[0], oe_n[0], busy[0], fdone[0]} !== 6'b000100) begin
      err++;
      $display("FAIL reset_async: got %b, expected 000100",
               {sclk[0], sdata[0], latch[0], oe_n[0], busy[0], fdone[0]});
    end
    q0.delete(); q1.delete(); q2.delete();
    q0.push_back(exp_word(led0, 1'b0));
    q1.push_back(exp_word(led1, 1'b1));
    q2.push_back(exp_word(led2, 1'b0));
    repeat (2) @(negedge clk);
    rel = cyc;
    reset_n = 1'b1;
    wait_fdone(0, 400, "resend_frame", oe_early);
    chk++;
    if (cyc - rel !== 198) begin
      err++; $display("FAIL resend_done_time: got %0d, expected 198", cyc - rel);
    end
    chk++;
    if (oe_early !== 1'b0 || oe_n[0] !== 1'b0) begin
      err++; $display("FAIL resend_oe: early_low=%b at_done=%b, expected 0/0", oe_early, oe_n[0]);
    end
    repeat (3) @(negedge clk);
    chk++;
    if (q0.size() + q1.size() + q2.size() !== 0) begin
      err++; $display("FAIL scoreboard_drain: got %0d pending, expected 0",
                      q0.size() + q1.size() + q2.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      frames[i] = 0; busy_rise[i] = 0; period[i] = 0; nbits[i] = 0;
      latch_len[i] = 0; word[i] = '0; last_exp[i] = '0;
      prev_sclk[i] = 1'b0; prev_busy[i] = 1'b0;
    end
    fork
      monitor();
    join_none
    test_reset();
    test_first_frame();
    test_change_mid_frame();
    test_glitch();
    test_active_low();
    test_refresh();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
